// File: rtl/bnn_pkg.sv
// Shared BNN definitions: layer dimensions, arithmetic widths and the
// handshake FSM state encoding used by the output layer.
package bnn_pkg;

   localparam int NIN    = 128;
   localparam int NCLASS = 10;
   localparam int BW     = 8;
   localparam int SW     = 10;
   localparam int CW     = 4;
   localparam int PW     = $clog2(NIN + 1);

   typedef enum logic [2:0] {
      ST_WAIT     = 3'd0,
      ST_RCV      = 3'd1,
      ST_CALC     = 3'd2,
      ST_SND_WAIT = 3'd3,
      ST_SND      = 3'd4
   } state_t;

endpackage

// File: rtl/weight_rom_out.sv
// Output-layer weight/bias ROM: combinational read of one class row.
// Contents are fixed at elaboration through the W3_INIT / B3_INIT parameters.
module weight_rom_out
   import bnn_pkg::*;
#(
   parameter logic [NCLASS*NIN-1:0] W3_INIT = '0,
   parameter logic [NCLASS*BW-1:0]  B3_INIT = '0
) (
   input  logic [CW-1:0]  maddress,
   output logic [NIN-1:0] mw3,
   output logic [BW-1:0]  mb3
);

   // One-hot row select; unused addresses read as zero.
   always_comb begin
      mw3 = '0;
      mb3 = '0;
      for (int i = 0; i < NCLASS; i++) begin
         mw3 = mw3 | ({NIN{maddress == CW'(i)}} & W3_INIT[i*NIN +: NIN]);
         mb3 = mb3 | ({BW{maddress == CW'(i)}} & B3_INIT[i*BW +: BW]);
      end
   end

endmodule

// File: rtl/out_layer.sv
// Final BNN stage: XNOR-popcount plus bias per class, argmax over NCLASS
// classes, returned over a req/ack handshake.
module out_layer
   import bnn_pkg::*;
#(
   parameter logic [NCLASS*NIN-1:0] W3_INIT = '0,
   parameter logic [NCLASS*BW-1:0]  B3_INIT = '0
) (
   input  logic                 clk,
   input  logic                 xrst,
   input  logic [NIN-1:0]       inputs,
   input  logic                 rcv_ack,
   input  logic                 snd_req,
   output logic                 rcv_req,
   output logic                 snd_ack,
   output logic [CW-1:0]        class_id,
   output logic signed [SW-1:0] max_score
);

   function automatic logic [PW-1:0] popcount(input logic [NIN-1:0] v);
      logic [PW-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < NIN; i++) cnt = cnt + PW'(v[i]);
      return cnt;
   endfunction

   state_t                r_st, w_st_nxt;
   logic [NIN-1:0]        r_inputs_mem;
   logic [CW-1:0]         r_idx, r_idx_d, r_cnt, r_best_id, r_class_id;
   logic                  r_s1_vld;
   logic signed [SW-1:0]  r_score, r_best, r_max_score;
   logic [NIN-1:0]        w_w3;
   logic [BW-1:0]         w_b3;
   logic [PW-1:0]         w_pop;
   logic signed [SW-1:0]  w_score, w_best_nxt;
   logic [CW-1:0]         w_best_id_nxt;
   logic                  w_upd, w_calc_done;

   weight_rom_out #(.W3_INIT(W3_INIT), .B3_INIT(B3_INIT)) u_rom (
      .maddress (r_idx),
      .mw3      (w_w3),
      .mb3      (w_b3)
   );

   assign w_pop       = popcount(r_inputs_mem ^ w_w3);
   assign w_score     = SW'(NIN) - {{(SW-PW){1'b0}}, w_pop} + {{(SW-BW){w_b3[BW-1]}}, w_b3};
   assign w_calc_done = (r_st == ST_CALC) && (r_cnt == CW'(NCLASS));
   // Strict compare keeps the lowest index on ties.
   assign w_upd         = (r_idx_d == '0) || (r_score > r_best);
   assign w_best_nxt    = w_upd ? r_score : r_best;
   assign w_best_id_nxt = w_upd ? r_idx_d : r_best_id;

   assign rcv_req   = (r_st == ST_WAIT);
   assign snd_ack   = (r_st == ST_SND);
   assign class_id  = r_class_id;
   assign max_score = r_max_score;

   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) r_st <= ST_WAIT;
      else       r_st <= w_st_nxt;
   end

   always_comb begin
      w_st_nxt = r_st;
      case (r_st)
         ST_WAIT:     w_st_nxt = rcv_ack ? ST_RCV : ST_WAIT;
         ST_RCV:      w_st_nxt = ST_CALC;
         ST_CALC:     w_st_nxt = w_calc_done ? ST_SND_WAIT : ST_CALC;
         ST_SND_WAIT: w_st_nxt = snd_req ? ST_SND : ST_SND_WAIT;
         ST_SND:      w_st_nxt = snd_req ? ST_SND : ST_WAIT;
         default:     w_st_nxt = ST_WAIT;
      endcase
   end

   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         r_inputs_mem <= '0;
         r_idx        <= '0;
         r_idx_d      <= '0;
         r_cnt        <= '0;
         r_s1_vld     <= 1'b0;
         r_score      <= '0;
         r_best       <= '0;
         r_best_id    <= '0;
         r_class_id   <= '0;
         r_max_score  <= '0;
      end else begin
         if (r_st == ST_RCV) r_inputs_mem <= inputs;
         r_s1_vld <= (r_st == ST_CALC) && (r_cnt < CW'(NCLASS));
         if (r_st == ST_CALC) begin
            r_score <= w_score;
            r_idx_d <= r_idx;
            r_cnt   <= w_calc_done ? '0 : r_cnt + 4'd1;
            if (w_calc_done)                 r_idx <= '0;
            else if (r_idx < CW'(NCLASS - 1)) r_idx <= r_idx + 4'd1;
         end
         if (r_s1_vld) begin
            r_best    <= w_best_nxt;
            r_best_id <= w_best_id_nxt;
         end
         // The final stage-2 result is folded in on the same edge CALC exits.
         if (w_calc_done) begin
            r_class_id  <= w_best_id_nxt;
            r_max_score <= w_best_nxt;
         end
      end
   end

endmodule

// File: tb/tb_out_layer.sv
// Self-checking bench for out_layer: directed argmax/tie/bias/handshake/reset
// cases plus random vectors against a behavioural argmax model.
module tb_out_layer;

   localparam int NC = 10;
   localparam logic [127:0] ROW_P  = 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5;
   localparam logic [127:0] ROW_Q  = 128'h3C3C_3C3C_3C3C_3C3C_3C3C_3C3C_3C3C_3C3C;
   localparam logic [127:0] ROW_R  = 128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F;
   localparam logic [127:0] MASK28 = 128'h0000_0000_0000_0000_0000_0000_0FFF_FFFF;
   localparam logic [127:0] ROW_0  = 128'h6969_6969_6969_6969_6969_6969_6969_6969;
   localparam logic [127:0] ROW_1  = ROW_R ^ MASK28;
   localparam logic [127:0] ROW_4  = 128'h9696_9696_9696_9696_9696_9696_9696_9696;
   localparam logic [127:0] ROW_6  = 128'hC3C3_C3C3_C3C3_C3C3_C3C3_C3C3_C3C3_C3C3;
   localparam logic [127:0] ROW_8  = 128'h5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A;
   localparam logic [127:0] ROW_9  = 128'hF0F0_F0F0_F0F0_F0F0_F0F0_F0F0_F0F0_F0F0;
   localparam logic [NC*128-1:0] W3 = {ROW_9, ROW_8, ROW_R, ROW_6, ROW_P,
                                       ROW_4, ROW_Q, ROW_P, ROW_1, ROW_0};
   localparam logic [NC*8-1:0] B3_A = '0;
   localparam logic [NC*8-1:0] B3_B = {8'h00, 8'h00, 8'h80, 8'h00, 8'h00,
                                       8'h00, 8'h00, 8'h00, 8'h14, 8'h00};

   logic              clk = 1'b0;
   logic              xrst;
   logic [127:0]      inputs;
   logic              rcv_ack, snd_req;
   logic              rcv_req_a, snd_ack_a, rcv_req_b, snd_ack_b;
   logic [3:0]        class_id_a, class_id_b;
   logic signed [9:0] max_score_a, max_score_b;

   logic [127:0] w_rows [NC];
   int           bias_b [NC];
   int           n_checks = 0;
   int           n_pass = 0;
   int           prev_cls_a = 0, prev_sc_a = 0, prev_cls_b = 0, prev_sc_b = 0;

   always #5 clk = ~clk;

   out_layer #(.W3_INIT(W3), .B3_INIT(B3_A)) u_dut_a (
      .clk(clk), .xrst(xrst), .inputs(inputs), .rcv_ack(rcv_ack), .snd_req(snd_req),
      .rcv_req(rcv_req_a), .snd_ack(snd_ack_a), .class_id(class_id_a), .max_score(max_score_a)
   );

   out_layer #(.W3_INIT(W3), .B3_INIT(B3_B)) u_dut_b (
      .clk(clk), .xrst(xrst), .inputs(inputs), .rcv_ack(rcv_ack), .snd_req(snd_req),
      .rcv_req(rcv_req_b), .snd_ack(snd_ack_b), .class_id(class_id_b), .max_score(max_score_b)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Argmax of (matches + bias), first index wins on ties.
   function automatic void ref_model(input logic [127:0] v, input bit use_b,
                                     output int cls, output int sc);
      int s;
      cls = 0;
      sc  = 0;
      for (int c = 0; c < NC; c++) begin
         s = 128 - $countones(v ^ w_rows[c]) + (use_b ? bias_b[c] : 0);
         if (c == 0 || s > sc) begin
            sc  = s;
            cls = c;
         end
      end
   endfunction

   task automatic do_vector(input logic [127:0] vec, input int hold, input string tag);
      int ecls_a, esc_a, ecls_b, esc_b;
      ref_model(vec, 1'b0, ecls_a, esc_a);
      ref_model(vec, 1'b1, ecls_b, esc_b);
      @(negedge clk);
      inputs  = vec;
      rcv_ack = 1'b1;
      @(negedge clk);
      rcv_ack = 1'b0;
      repeat (NC + 1) @(posedge clk);
      @(negedge clk);
      check({tag, "_early_cls"}, int'(class_id_a), prev_cls_a);
      check({tag, "_early_sc"},  int'(max_score_a), prev_sc_a);
      @(negedge clk);
      check({tag, "_cls_a"},   int'(class_id_a),  ecls_a);
      check({tag, "_sc_a"},    int'(max_score_a), esc_a);
      check({tag, "_cls_b"},   int'(class_id_b),  ecls_b);
      check({tag, "_sc_b"},    int'(max_score_b), esc_b);
      check({tag, "_busy_rq"}, int'(rcv_req_a),   0);
      repeat (hold) @(negedge clk);
      check({tag, "_hold_ack"}, int'(snd_ack_a | snd_ack_b), 0);
      check({tag, "_hold_rq"},  int'(rcv_req_a | rcv_req_b), 0);
      snd_req = 1'b1;
      @(negedge clk);
      check({tag, "_snd_ack"}, int'(snd_ack_a & snd_ack_b), 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      snd_req = 1'b0;
      @(negedge clk);
      check({tag, "_ack_drop"}, int'(snd_ack_a | snd_ack_b), 0);
      check({tag, "_rq_back"},  int'(rcv_req_a & rcv_req_b), 1);
      check({tag, "_held_cls"}, int'(class_id_b), ecls_b);
      prev_cls_a = ecls_a;
      prev_sc_a  = esc_a;
      prev_cls_b = ecls_b;
      prev_sc_b  = esc_b;
   endtask

   initial begin
      logic [127:0] v;
      w_rows = '{ROW_0, ROW_1, ROW_P, ROW_Q, ROW_4, ROW_P, ROW_6, ROW_R, ROW_8, ROW_9};
      bias_b = '{0, 20, 0, 0, 0, 0, 0, -128, 0, 0};
      xrst    = 1'b0;
      inputs  = '0;
      rcv_ack = 1'b0;
      snd_req = 1'b0;
      repeat (3) @(negedge clk);
      xrst = 1'b1;
      @(negedge clk);
      check("rst_rcv_req",   int'(rcv_req_a & rcv_req_b), 1);
      check("rst_snd_ack",   int'(snd_ack_a | snd_ack_b), 0);
      check("rst_class_id",  int'(class_id_a | class_id_b), 0);
      check("rst_max_score", int'(max_score_a | max_score_b), 0);

      do_vector(ROW_Q, 20, "row3");
      check("row3_cls",  int'(class_id_a), 3);
      check("row3_sc",   int'(max_score_a), 128);
      do_vector(ROW_P, 3, "tie");
      check("tie_cls",   int'(class_id_a), 2);
      check("tie_sc",    int'(max_score_a), 128);
      do_vector(ROW_R, 5, "bias");
      check("bias_cls",  int'(class_id_b), 1);
      check("bias_sc",   int'(max_score_b), 120);
      check("nobias_cls", int'(class_id_a), 7);

      // Abort while the class index is at 4.
      @(negedge clk);
      inputs  = ROW_Q;
      rcv_ack = 1'b1;
      @(negedge clk);
      rcv_ack = 1'b0;
      repeat (5) @(posedge clk);
      #1 xrst = 1'b0;
      #1;
      check("abort_rcv_req", int'(rcv_req_a & rcv_req_b), 1);
      check("abort_cls_a",   int'(class_id_a), 0);
      check("abort_cls_b",   int'(class_id_b), 0);
      check("abort_sc_b",    int'(max_score_b), 0);
      @(negedge clk);
      xrst = 1'b1;
      prev_cls_a = 0; prev_sc_a = 0; prev_cls_b = 0; prev_sc_b = 0;
      do_vector(ROW_P, 1, "post_rst");
      check("post_rst_cls", int'(class_id_a), 2);

      for (int n = 0; n < 16; n++) begin
         if (n % 4 == 3) begin
            v = {$urandom(), $urandom(), $urandom(), $urandom()};
         end else begin
            v = w_rows[$urandom_range(0, NC - 1)];
            repeat ($urandom_range(0, 40)) v[$urandom_range(0, 127)] ^= 1'b1;
         end
         do_vector(v, $urandom_range(0, 6), $sformatf("rnd%0d", n));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
